// File: rtl/dm_responder_pkg.sv
// Shared definitions for the data-memory responder: dump FSM encoding and default widths.
package dm_responder_pkg;

  localparam int unsigned DefAddrWidth = 8;
  localparam int unsigned DefDataWidth = 16;

  typedef enum logic [1:0] {
    StRun  = 2'd0,
    StDump = 2'd1,
    StDone = 2'd2
  } dump_state_e;

endpackage

// File: rtl/dm_dump_ctrl.sv
// Dump sequencer: walks the pointer over every implemented word on a valid/ready channel,
// then emits a single-cycle done pulse.
module dm_dump_ctrl
  import dm_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dump_start,
  input  logic                  dump_ready,
  output logic                  dump_valid,
  output logic                  dump_done,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic                  dumping
);

  // One extra bit so DEPTH == 2**ADDR_WIDTH never wraps the last index.
  localparam int unsigned PtrWidth = ADDR_WIDTH + 1;
  localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(DEPTH - 1);

  dump_state_e         state_q;
  logic [PtrWidth-1:0] ptr_q;
  logic                dump_valid_q;
  logic                dump_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StRun;
      ptr_q        <= '0;
      dump_valid_q <= 1'b0;
      dump_done_q  <= 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          dump_done_q <= 1'b0;
          if (dump_start) begin
            state_q      <= StDump;
            ptr_q        <= '0;
            dump_valid_q <= 1'b1;
          end
        end
        StDump: begin
          if (dump_ready) begin
            if (ptr_q == LastPtr) begin
              state_q      <= StDone;
              dump_valid_q <= 1'b0;
              dump_done_q  <= 1'b1;
            end else begin
              ptr_q <= ptr_q + PtrWidth'(1);
            end
          end
        end
        StDone: begin
          dump_done_q <= 1'b0;
          state_q     <= StRun;
        end
        default: begin
          state_q      <= StRun;
          dump_valid_q <= 1'b0;
          dump_done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dump_valid = dump_valid_q;
  assign dump_done  = dump_done_q;
  assign dump_addr  = ptr_q[ADDR_WIDTH-1:0];
  assign dumping    = (state_q == StDump);

endmodule

// File: rtl/dm_responder.sv
// Memory side of the processor DM interface: load/store service, preload port, sticky error
// flags and a post-run dump of the whole array.
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DefAddrWidth,
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic                  dm_rd,
  input  logic                  dm_wr,
  input  logic [DATA_WIDTH-1:0] dm_w_data,
  output logic [DATA_WIDTH-1:0] dm_r_data,
  input  logic                  ld_en,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  input  logic                  dump_start,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_done,
  output logic                  addr_err,
  output logic                  coll_err
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  addr_err_q;
  logic                  coll_err_q;
  logic                  dm_in_range;
  logic                  ld_in_range;
  logic                  dumping;

  dm_dump_ctrl #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_dump_ctrl (
    .clk        (clk),
    .rst        (rst),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_done  (dump_done),
    .dump_addr  (dump_addr),
    .dumping    (dumping)
  );

  assign dm_in_range = 32'(dm_addr) < DEPTH;
  assign ld_in_range = 32'(ld_addr) < DEPTH;

  assign rd_data   = dm_in_range ? mem[dm_addr] : '0;
  assign dm_r_data = dm_rd ? rd_data : hold_q;
  assign dump_data = mem[dump_addr];

  // No reset on the array: preloaded contents must survive rst.
  always_ff @(posedge clk) begin
    if (!dumping) begin
      if (ld_en) begin
        if (ld_in_range) mem[ld_addr] <= ld_data;
      end else if (dm_wr && dm_in_range) begin
        mem[dm_addr] <= dm_w_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= '0;
      addr_err_q <= 1'b0;
      coll_err_q <= 1'b0;
    end else begin
      if (dm_rd) hold_q <= rd_data;
      if (((dm_rd || dm_wr) && !dm_in_range) || (ld_en && !ld_in_range)) addr_err_q <= 1'b1;
      if ((ld_en && dm_wr) || (dumping && (ld_en || dm_wr))) coll_err_q <= 1'b1;
    end
  end

  assign addr_err = addr_err_q;
  assign coll_err = coll_err_q;

endmodule

// File: tb/tb_dm_responder.sv
// Self-checking bench for dm_responder: vector table for load/store/preload/range behaviour,
// scoreboarded dump with random back-pressure, and reset during a dump.
module tb_dm_responder;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 200;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] dm_addr;
  logic          dm_rd;
  logic          dm_wr;
  logic [DW-1:0] dm_w_data;
  logic [DW-1:0] dm_r_data;
  logic          ld_en;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_data;
  logic          dump_start;
  logic          dump_valid;
  logic          dump_ready;
  logic [AW-1:0] dump_addr;
  logic [DW-1:0] dump_data;
  logic          dump_done;
  logic          addr_err;
  logic          coll_err;

  dm_responder #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .dm_addr    (dm_addr),
    .dm_rd      (dm_rd),
    .dm_wr      (dm_wr),
    .dm_w_data  (dm_w_data),
    .dm_r_data  (dm_r_data),
    .ld_en      (ld_en),
    .ld_addr    (ld_addr),
    .ld_data    (ld_data),
    .dump_start (dump_start),
    .dump_valid (dump_valid),
    .dump_ready (dump_ready),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_done  (dump_done),
    .addr_err   (addr_err),
    .coll_err   (coll_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rd;
    logic          wr;
    logic          ld;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [AW-1:0] laddr;
    logic [DW-1:0] ldata;
    logic [DW-1:0] exp_r;
    logic          exp_ae;
    logic          exp_ce;
  } vec_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } dump_exp_t;

  int n_pass  = 0;
  int n_total = 0;
  vec_t      vecs [16];
  dump_exp_t sb [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic idle_inputs();
    dm_rd = 0; dm_wr = 0; dm_addr = '0; dm_w_data = '0;
    ld_en = 0; ld_addr = '0; ld_data = '0;
    dump_start = 0; dump_ready = 0;
  endtask

  initial begin
    dump_exp_t e;
    int accepted, done_cnt, budget;
    logic prev_stall;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_data;

    //         rd wr ld addr   wdata     laddr  ldata     exp_r     ae ce
    vecs[0]  = '{0, 0, 1, 8'h00, 16'h0000, 8'h10, 16'hBEEF, 16'h0000, 0, 0};
    vecs[1]  = '{1, 0, 0, 8'h10, 16'h0000, 8'h00, 16'h0000, 16'hBEEF, 0, 0};
    vecs[2]  = '{0, 0, 0, 8'h00, 16'h0000, 8'h00, 16'h0000, 16'hBEEF, 0, 0};
    vecs[3]  = '{0, 0, 1, 8'h00, 16'h0000, 8'h20, 16'h0001, 16'hBEEF, 0, 0};
    vecs[4]  = '{1, 1, 0, 8'h20, 16'h1234, 8'h00, 16'h0000, 16'h0001, 0, 0};
    vecs[5]  = '{1, 0, 0, 8'h20, 16'h0000, 8'h00, 16'h0000, 16'h1234, 0, 0};
    vecs[6]  = '{0, 0, 1, 8'h00, 16'h0000, 8'h70, 16'h1111, 16'h1234, 0, 0};
    vecs[7]  = '{0, 1, 0, 8'h41, 16'h7777, 8'h00, 16'h0000, 16'h1234, 0, 0};
    vecs[8]  = '{1, 0, 0, 8'h41, 16'h0000, 8'h00, 16'h0000, 16'h7777, 0, 0};
    vecs[9]  = '{0, 1, 1, 8'h30, 16'h5555, 8'h30, 16'hAAAA, 16'h7777, 0, 0};
    vecs[10] = '{1, 0, 0, 8'h30, 16'h0000, 8'h00, 16'h0000, 16'hAAAA, 0, 1};
    vecs[11] = '{1, 0, 0, 8'hF0, 16'h0000, 8'h00, 16'h0000, 16'h0000, 0, 1};
    vecs[12] = '{0, 0, 0, 8'h00, 16'h0000, 8'h00, 16'h0000, 16'h0000, 1, 1};
    vecs[13] = '{0, 1, 0, 8'hF0, 16'hDEAD, 8'h00, 16'h0000, 16'h0000, 1, 1};
    vecs[14] = '{1, 0, 0, 8'h70, 16'h0000, 8'h00, 16'h0000, 16'h1111, 1, 1};
    vecs[15] = '{1, 0, 0, 8'hF0, 16'h0000, 8'h00, 16'h0000, 16'h0000, 1, 1};

    idle_inputs();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    check("reset_dump_valid", 32'(dump_valid), 0);
    check("reset_dump_done", 32'(dump_done), 0);
    check("reset_addr_err", 32'(addr_err), 0);
    check("reset_coll_err", 32'(coll_err), 0);
    check("reset_hold", 32'(dm_r_data), 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      dm_rd = vecs[i].rd; dm_wr = vecs[i].wr; ld_en = vecs[i].ld;
      dm_addr = vecs[i].addr; dm_w_data = vecs[i].wdata;
      ld_addr = vecs[i].laddr; ld_data = vecs[i].ldata;
      #1;
      check($sformatf("vec%0d_rdata", i), 32'(dm_r_data), 32'(vecs[i].exp_r));
      check($sformatf("vec%0d_addr_err", i), 32'(addr_err), 32'(vecs[i].exp_ae));
      check($sformatf("vec%0d_coll_err", i), 32'(coll_err), 32'(vecs[i].exp_ce));
    end

    // Flags clear on reset, array survives it.
    @(negedge clk);
    idle_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
    dm_rd = 1; dm_addr = 8'h10;
    #1;
    check("rst_clears_addr_err", 32'(addr_err), 0);
    check("rst_clears_coll_err", 32'(coll_err), 0);
    check("mem_survives_rst", 32'(dm_r_data), 32'hBEEF);

    for (int i = 0; i < int'(DEPTH); i++) begin
      @(negedge clk);
      idle_inputs();
      ld_en = 1; ld_addr = AW'(i); ld_data = DW'(i);
    end

    @(negedge clk);
    idle_inputs();
    dump_start = 1;
    for (int i = 0; i < int'(DEPTH); i++) sb.push_back('{AW'(i), DW'(i)});
    accepted = 0; done_cnt = 0; budget = 0; prev_stall = 0;
    prev_addr = '0; prev_data = '0;
    while (accepted < int'(DEPTH) && budget < 4000) begin
      @(negedge clk);
      budget++;
      idle_inputs();
      dump_ready = 1'($urandom_range(0, 1));
      if (budget == 1) begin
        dm_wr = 1; dm_addr = 8'd5; dm_w_data = 16'hFFFF;
      end
      if (budget == 2) begin
        dm_rd = 1; dm_addr = 8'd7;
      end
      #1;
      if (budget == 2) check("rd_during_dump", 32'(dm_r_data), 7);
      if (dump_done) done_cnt++;
      if (!dump_valid) check("dump_valid_high", 32'(dump_valid), 1);
      else begin
        if (prev_stall) begin
          check("stall_addr_stable", 32'(dump_addr), 32'(prev_addr));
          check("stall_data_stable", 32'(dump_data), 32'(prev_data));
        end
        if (dump_ready) begin
          e = sb.pop_front();
          check("dump_addr", 32'(dump_addr), 32'(e.addr));
          check("dump_data", 32'(dump_data), 32'(e.data));
          accepted++;
        end
        prev_stall = !dump_ready;
        prev_addr = dump_addr;
        prev_data = dump_data;
      end
    end
    check("dump_accept_count", 32'(accepted), DEPTH);
    check("dump_sb_empty", 32'(sb.size()), 0);
    check("no_early_done", 32'(done_cnt), 0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("done_pulse", 32'(dump_done), 1);
    check("valid_low_in_done", 32'(dump_valid), 0);
    @(negedge clk);
    #1;
    check("done_single_cycle", 32'(dump_done), 0);
    check("coll_err_wr_in_dump", 32'(coll_err), 1);
    dm_rd = 1; dm_addr = 8'd5;
    #1;
    check("wr_in_dump_ignored", 32'(dm_r_data), 5);

    // Reset while the pointer sits at word 5.
    @(negedge clk);
    idle_inputs();
    dump_start = 1;
    @(negedge clk);
    dump_start = 0;
    dump_ready = 1;
    budget = 0;
    #1;
    while (!(dump_valid && dump_addr == 8'd5) && budget < 50) begin
      @(negedge clk);
      budget++;
      #1;
    end
    check("reached_ptr5", 32'(dump_addr), 5);
    rst = 1;
    dump_ready = 0;
    @(negedge clk);
    #1;
    check("rst_mid_dump_valid", 32'(dump_valid), 0);
    check("rst_mid_dump_done", 32'(dump_done), 0);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("run_after_rst_valid", 32'(dump_valid), 0);
      check("run_after_rst_done", 32'(dump_done), 0);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      dm_rd = 1; dm_addr = AW'(i);
      #1;
      check($sformatf("mem_after_rst_%0d", i), 32'(dm_r_data), 32'(i));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
